tone_gen: RTL and testbench
===========================

Name: tone_gen

Overview:
- Synthesizable test-tone source: the producer end of the filter sample interface (drives lowpassIn-style 16-bit signed samples).
- Generates a digital sine at fs = 48 kHz from the 144 kHz system clock, using a phase accumulator and a quarter-wave LUT.
- Emits one new sample every CLKS_PER_SAMPLE clocks, with a one-cycle strobe.
- Replaces hand-coded sample sequences and feeds the filter chain directly on hardware.

Parameters:
- CLKS_PER_SAMPLE, 3: clk_144 cycles per output sample (144 kHz / 48 kHz).
- PHASE_W, 16: phase accumulator width. Tuning word = f * 2^PHASE_W / 48000.
- LUT_AW, 6: quarter-wave LUT address bits. LUT holds 2^LUT_AW + 1 entries. Constraint: LUT_AW <= PHASE_W - 2.

Ports:
- clk_144  in  1  system clock, 144 kHz
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = generate tone; 0 = silence and phase clear
- toneInc  in  PHASE_W  phase increment per sample (tuning word)
- ampShift  in  3  attenuation, arithmetic right shift 0..7 (used only with TONE_AMP_EN)
- toneOut  out  16  signed sample, two's complement
- sampleValid  out  1  one-cycle pulse, coincident with each new toneOut value

Behaviour:
- Reset (asynchronous assert, synchronous-to-clock release): divCnt=0, phase=0, toneOut=0, sampleValid=0.
- Divider:
  - divCnt counts 0..CLKS_PER_SAMPLE-1 and wraps.
  - The tick is the cycle where divCnt == CLKS_PER_SAMPLE-1.
  - The divider always runs, independent of enable.
- On each tick edge:
  - If enable=1: toneOut <= sine(phase); phase <= phase + toneInc, modulo 2^PHASE_W.
  - If enable=0: toneOut <= 0; phase <= 0.
  - In both cases, sampleValid is high for the cycle following the tick edge, otherwise 0.
  - toneOut holds its value between ticks.
- Sample latency: the first sample after reset or after enable rises is sine(0) = 0. toneInc is sampled only at tick edges, so changes take effect on the next sample with no glitch.
- First strobe: sampleValid is first high in cycle CLKS_PER_SAMPLE after reset release (clock counted from 0). Strobes then follow every CLKS_PER_SAMPLE clocks.
- Sine lookup:
  - q = phase[PHASE_W-1:PHASE_W-2]; idx = phase[PHASE_W-3:PHASE_W-2-LUT_AW]. Lower bits are truncated, no interpolation.
  - LUT[k] = round(32767 * sin(pi/2 * k / 2^LUT_AW)), k = 0..2^LUT_AW, so LUT[64] = 32767.
  - Quadrant mapping:
    - q=0: +LUT[idx]
    - q=1: +LUT[2^LUT_AW - idx]
    - q=2: -LUT[idx]
    - q=3: -LUT[2^LUT_AW - idx]
  - Output range is -32767..+32767. -32768 is never produced, and negation never overflows.
  - The lookup path is purely combinational from phase; the only register is toneOut.
- Boundary cases:
  - toneInc=0: constant output sine(phase). The phase is frozen, so after enable the output is 0.
  - toneInc = 2^(PHASE_W-1): Nyquist. Output alternates 0, 0 (sin 0, sin pi), i.e. all zeros.
  - Phase wrap: silent modulo arithmetic, no flag.
  - enable falling mid-sample: takes effect at the next tick only. toneOut is not cleared early.
  - Reset mid-operation: all state returns immediately to reset values.

Optional Feature:
- TONE_AMP_EN defined:
  - toneOut = sine(phase) >>> ampShift (arithmetic shift, sign preserved), applied before the output register.
  - Example: ampShift=1 gives a peak of 16383; -32767 >>> 1 gives -16384.
  - ampShift is sampled at tick edges.
- TONE_AMP_EN undefined:
  - ampShift is ignored and no shifter is built; full-scale output only.
  - The port remains, for interface stability.

Test Plan:
- Reset then enable=1, toneInc=4096 (3 kHz): successive samples are 0, 12539, 23170, 30273, 32767, 30273, 23170, 12539, 0, -12539, -23170, -30273, -32767, -30273, -23170, -12539, then the sequence repeats. sampleValid pulses every 3 clocks.
- toneInc=1365 (≈1 kHz): 48 samples per period. Peak +32767 near sample 12, trough -32767 near sample 36. Check the zero crossing at sample 24 is within ±1 LUT step.
- enable toggled 1→0→1 mid-tone: first tick after the fall gives toneOut=0 and phase=0. First sample after re-enable is 0, the second is LUT for toneInc.
- toneInc changed 4096→8192 between ticks: the new increment applies from the next sample; the phase step doubles with no missing or duplicated strobe.
- Assert reset_n=0 asynchronously between clock edges mid-sequence: toneOut=0 and sampleValid=0 immediately. After release, the first strobe is 3 clocks later with value 0.
- TONE_AMP_EN defined, ampShift=2, toneInc=4096: peak 8191, trough -8192 (-32767 >>> 2). With the macro undefined, the same stimulus gives a peak of 32767.

Source files
------------

// File: rtl/tone_gen_if.sv
// tone_gen_if: control inputs and the 16-bit signed sample stream of the tone source.
// master = tone_gen (drives samples); slave = the controller/consumer side.
interface tone_gen_if #(
  parameter int PHASE_W = 16
);
  logic                  enable;
  logic [PHASE_W-1:0]    toneInc;
  logic [2:0]            ampShift;
  logic signed [15:0]    toneOut;
  logic                  sampleValid;

  modport master (
    input  enable,
    input  toneInc,
    input  ampShift,
    output toneOut,
    output sampleValid
  );

  modport slave (
    output enable,
    output toneInc,
    output ampShift,
    input  toneOut,
    input  sampleValid
  );
endinterface

// File: rtl/tone_gen.sv
// tone_gen: phase-accumulator sine source, quarter-wave LUT, one strobed sample per CLKS_PER_SAMPLE clocks.
// Build macro TONE_AMP_EN adds an ampShift arithmetic-shift attenuator; LUT_AW is limited to 1..6 and PHASE_W-2.
module tone_gen #(
  parameter int CLKS_PER_SAMPLE = 3,
  parameter int PHASE_W         = 16,
  parameter int LUT_AW          = 6
) (
  input  logic       clk_144,
  input  logic       reset_n,
  tone_gen_if.master tone
);

  localparam int DIV_W      = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int LUT_N      = 1 << LUT_AW;
  localparam int BASE_SHIFT = 6 - LUT_AW;
  localparam logic [LUT_AW:0]  LUT_TOP  = LUT_N[LUT_AW:0];
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_SAMPLE - 1);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic signed [15:0] tone_q, tone_d;
  logic               valid_q, valid_d;
  logic               tick;

  logic [1:0]         quad;
  logic [LUT_AW-1:0]  idx;
  logic [LUT_AW:0]    lut_addr;
  logic [6:0]         base_addr;
  logic [15:0]        mag;
  logic signed [15:0] sine_val;
  logic signed [15:0] shaped;

  // Quarter-wave table at 64-step resolution; smaller LUT_AW reads every 2^(6-LUT_AW)-th entry.
  function automatic logic [14:0] quarter_sine(input logic [6:0] k);
    logic [14:0] v;
    case (k)
      7'd0:  v = 15'd0;     7'd1:  v = 15'd804;   7'd2:  v = 15'd1608;  7'd3:  v = 15'd2410;
      7'd4:  v = 15'd3212;  7'd5:  v = 15'd4011;  7'd6:  v = 15'd4808;  7'd7:  v = 15'd5602;
      7'd8:  v = 15'd6393;  7'd9:  v = 15'd7179;  7'd10: v = 15'd7962;  7'd11: v = 15'd8739;
      7'd12: v = 15'd9512;  7'd13: v = 15'd10278; 7'd14: v = 15'd11039; 7'd15: v = 15'd11793;
      7'd16: v = 15'd12539; 7'd17: v = 15'd13279; 7'd18: v = 15'd14010; 7'd19: v = 15'd14732;
      7'd20: v = 15'd15446; 7'd21: v = 15'd16151; 7'd22: v = 15'd16846; 7'd23: v = 15'd17530;
      7'd24: v = 15'd18204; 7'd25: v = 15'd18868; 7'd26: v = 15'd19519; 7'd27: v = 15'd20159;
      7'd28: v = 15'd20787; 7'd29: v = 15'd21403; 7'd30: v = 15'd22005; 7'd31: v = 15'd22594;
      7'd32: v = 15'd23170; 7'd33: v = 15'd23731; 7'd34: v = 15'd24279; 7'd35: v = 15'd24811;
      7'd36: v = 15'd25329; 7'd37: v = 15'd25832; 7'd38: v = 15'd26319; 7'd39: v = 15'd26790;
      7'd40: v = 15'd27245; 7'd41: v = 15'd27683; 7'd42: v = 15'd28105; 7'd43: v = 15'd28510;
      7'd44: v = 15'd28898; 7'd45: v = 15'd29268; 7'd46: v = 15'd29621; 7'd47: v = 15'd29956;
      7'd48: v = 15'd30273; 7'd49: v = 15'd30571; 7'd50: v = 15'd30852; 7'd51: v = 15'd31113;
      7'd52: v = 15'd31356; 7'd53: v = 15'd31580; 7'd54: v = 15'd31785; 7'd55: v = 15'd31971;
      7'd56: v = 15'd32137; 7'd57: v = 15'd32285; 7'd58: v = 15'd32412; 7'd59: v = 15'd32521;
      7'd60: v = 15'd32609; 7'd61: v = 15'd32678; 7'd62: v = 15'd32728; 7'd63: v = 15'd32757;
      7'd64: v = 15'd32767;
      default: v = 15'd0;
    endcase
    return v;
  endfunction

  assign tick = (div_cnt_q == DIV_LAST);

  // Lookup is purely combinational from phase; odd quadrants read the table mirrored.
  assign quad = phase_q[PHASE_W-1 -: 2];
  assign idx  = phase_q[PHASE_W-3 -: LUT_AW];

  always_comb begin
    lut_addr  = quad[0] ? (LUT_TOP - {1'b0, idx}) : {1'b0, idx};
    base_addr = 7'(lut_addr) << BASE_SHIFT;
    mag       = {1'b0, quarter_sine(base_addr)};
    sine_val  = quad[1] ? -$signed(mag) : $signed(mag);
  end

`ifdef TONE_AMP_EN
  assign shaped = sine_val >>> tone.ampShift;
`else
  logic amp_unused;
  assign amp_unused = ^tone.ampShift;
  assign shaped     = sine_val;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    phase_d   = phase_q;
    tone_d    = tone_q;
    valid_d   = tick;
    if (tick) begin
      if (tone.enable) begin
        tone_d  = shaped;
        phase_d = phase_q + tone.toneInc;
      end else begin
        tone_d  = '0;
        phase_d = '0;
      end
    end
  end

  // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      phase_q   <= '0;
      tone_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
      tone_q    <= tone_d;
      valid_q   <= valid_d;
    end
  end

  assign tone.toneOut     = tone_q;
  assign tone.sampleValid = valid_q;

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: directed-vector bench for tone_gen with hand-computed sine samples.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_tone_gen;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   v;
  int   gap;

  tone_gen_if #(.PHASE_W(16)) tif ();

  tone_gen #(
    .CLKS_PER_SAMPLE(3),
    .PHASE_W        (16),
    .LUT_AW         (6)
  ) dut (
    .clk_144(clk),
    .reset_n(rst_n),
    .tone   (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

`ifdef TONE_AMP_EN
  localparam int AMP_S1     = 3134;
  localparam int AMP_PEAK   = 8191;
  localparam int AMP_TROUGH = -8192;
`else
  localparam int AMP_S1     = 12539;
  localparam int AMP_PEAK   = 32767;
  localparam int AMP_TROUGH = -32767;
`endif

  int exp_3k [16] = '{0, 12539, 23170, 30273, 32767, 30273, 23170, 12539,
                      0, -12539, -23170, -30273, -32767, -30273, -23170, -12539};

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next strobe; gap is the number of falling edges it took.
  task automatic next_sample(input string tag, output int val, output int cycles);
    cycles = 0;
    val    = 0;
    for (int i = 1; i <= 8 && cycles == 0; i++) begin
      @(negedge clk);
      if (tif.sampleValid === 1'b1) cycles = i;
    end
    if (cycles == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=no strobe in 8 clocks expected=strobe", tag);
    end else begin
      val = int'(tif.toneOut);
    end
  endtask

  task automatic sample_check(input string tag, input int exp, input int exp_gap);
    int sv;
    int sg;
    next_sample(tag, sv, sg);
    check({tag, "_val"}, sv, exp);
    check({tag, "_gap"}, sg, exp_gap);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    tif.enable   = 1'b0;
    tif.toneInc  = 16'd0;
    tif.ampShift = 3'd0;

    // Reset state
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tone", int'(tif.toneOut), 0);
    check("rst_valid", int'(tif.sampleValid), 0);

    // 3 kHz tone: first strobe 3 clocks after release, value sine(0)
    tif.enable  = 1'b1;
    tif.toneInc = 16'd4096;
    rst_n       = 1'b1;
    sample_check("first3k", 0, 3);
    for (int k = 1; k <= 16; k++)
      sample_check($sformatf("sine3k_%0d", k), exp_3k[k % 16], 3);

    // Increment 4096 -> 8192 between ticks: phase 4096 -> 12288 -> 20480 -> 28672 -> 36864
    tif.toneInc = 16'd8192;
    sample_check("inc_a", 12539, 3);
    sample_check("inc_b", 30273, 3);
    sample_check("inc_c", 30273, 3);
    sample_check("inc_d", 12539, 3);
    sample_check("inc_e", -12539, 3);

    // Enable falls mid-sample: output held until the next tick, then zero with phase cleared
    tif.enable = 1'b0;
    @(negedge clk);
    check("hold_tone", int'(tif.toneOut), -12539);
    check("hold_valid", int'(tif.sampleValid), 0);
    sample_check("dis_a", 0, 2);
    sample_check("dis_b", 0, 3);
    tif.enable = 1'b1;
    sample_check("reen_a", 0, 3);
    sample_check("reen_b", 23170, 3);
    sample_check("reen_c", 32767, 3);

    // Asynchronous reset between edges while the strobe is high
    #2 rst_n = 1'b0;
    #1;
    check("arst_tone", int'(tif.toneOut), 0);
    check("arst_valid", int'(tif.sampleValid), 0);
    @(negedge clk);
    tif.toneInc = 16'd1365;
    tif.enable  = 1'b1;
    rst_n       = 1'b1;
    sample_check("arst_first", 0, 3);

    // ~1 kHz: sample k reads phase k*1365 (12 -> 16380, 24 -> 32760, 36 -> 49140)
    for (int k = 1; k <= 36; k++) begin
      next_sample($sformatf("sine1k_%0d", k), v, gap);
      if (k == 12) check("sine1k_peak", v, 32757);
      if (k == 24) check("sine1k_zero", v, 804);
      if (k == 36) check("sine1k_trough", v, -32757);
    end

    // Nyquist from phase 0: all zeros
    tif.enable = 1'b0;
    sample_check("nyq_clr", 0, 3);
    tif.enable  = 1'b1;
    tif.toneInc = 16'd32768;
    for (int k = 0; k < 4; k++)
      sample_check($sformatf("nyq_%0d", k), 0, 3);

    // Zero increment freezes the phase at 4096
    tif.toneInc = 16'd4096;
    sample_check("frz_a", 0, 3);
    tif.toneInc = 16'd0;
    sample_check("frz_b", 12539, 3);
    sample_check("frz_c", 12539, 3);

    // Attenuation ampShift=2 (full scale when the shifter is not built)
    tif.enable = 1'b0;
    sample_check("amp_clr", 0, 3);
    tif.enable   = 1'b1;
    tif.toneInc  = 16'd4096;
    tif.ampShift = 3'd2;
    sample_check("amp_0", 0, 3);
    for (int k = 1; k <= 12; k++) begin
      next_sample($sformatf("amp_%0d", k), v, gap);
      if (k == 1)  check("amp_s1", v, AMP_S1);
      if (k == 4)  check("amp_peak", v, AMP_PEAK);
      if (k == 8)  check("amp_zero", v, 0);
      if (k == 12) check("amp_trough", v, AMP_TROUGH);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
